// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha keystream XOR stream block.
package chacha_pkg;

  localparam int unsigned BLK_BYTES = 64;
  localparam int unsigned IDX_W     = $clog2(BLK_BYTES);
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    HALT
  } chacha_state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } chacha_beat_t;

endpackage

// File: rtl/chacha_xor_stream_if.sv
// Plaintext-in / ciphertext-out byte stream bundle; the DUT side uses the slave modport.
interface chacha_xor_stream_if;
  import chacha_pkg::*;

  logic              pt_valid;
  logic [DATA_W-1:0] pt_data;
  logic              pt_last;
  logic              pt_ready;

  logic              ct_valid;
  logic [DATA_W-1:0] ct_data;
  logic              ct_last;
  logic              ct_ready;

  modport master (
    output pt_valid, pt_data, pt_last, ct_ready,
    input  pt_ready, ct_valid, ct_data, ct_last
  );

  modport slave (
    input  pt_valid, pt_data, pt_last, ct_ready,
    output pt_ready, ct_valid, ct_data, ct_last
  );

endinterface

// File: rtl/chacha_skid_reg.sv
// Single-entry registered valid/ready stage for one ciphertext byte plus its last flag.
module chacha_skid_reg
  import chacha_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  chacha_beat_t in_beat,
  output logic         in_ready_c,
  output logic         out_valid,
  output chacha_beat_t out_beat,
  input  logic         out_ready
);

  // Accept a new beat whenever the held one is absent or leaving this cycle.
  assign in_ready_c = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_beat <= in_beat;
      end
    end
  end

endmodule

// File: rtl/chacha_xor_stream.sv
// XORs plaintext bytes with ChaCha keystream bytes, tracking 64-byte block boundaries.
// Define CHACHA_XOR_SKIDBUF_EN to register the ciphertext output (1-cycle latency).
module chacha_xor_stream
  import chacha_pkg::*;
#(
  parameter int unsigned CTR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  chacha_xor_stream_if.slave bus,
  input  logic              ks_blk_ready,
  input  logic [DATA_W-1:0] ks_data,
  output logic              ks_rd_blk,
  output logic [CTR_W-1:0]  blk_cnt,
  output logic              blk_done,
  output logic              ctr_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_BYTES - 1);

  chacha_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              pt_ready_c;
  logic              fire_c;
  logic              ks_rd_c;
  logic              wrap_c;
  logic              ovf_c;
  logic              out_ready_c;
  chacha_beat_t      pt_beat_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus handshake/strobe decode; a counter wrap into HALT wins over everything.
  always_comb begin
    state_d    = state_q;
    pt_ready_c = 1'b0;
    fire_c     = 1'b0;
    ks_rd_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ks_blk_ready) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        pt_ready_c = ks_blk_ready & out_ready_c;
        fire_c     = bus.pt_valid & pt_ready_c;
        ks_rd_c    = fire_c;
      end
      FLUSH: begin
        ks_rd_c = ks_blk_ready;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    wrap_c = ks_rd_c & (idx_q == LAST_IDX);
    ovf_c  = wrap_c & (&blk_cnt);
    if (ovf_c) begin
      state_d = HALT;
    end else if ((state_q == STREAM) && fire_c && bus.pt_last && !wrap_c) begin
      state_d = FLUSH;
    end else if ((state_q == FLUSH) && wrap_c) begin
      state_d = STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      blk_cnt  <= '0;
      blk_done <= 1'b0;
      ctr_err  <= 1'b0;
    end else begin
      blk_done <= wrap_c;
      if (ks_rd_c) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (wrap_c) begin
        blk_cnt <= blk_cnt + CTR_W'(1);
      end
      if (ovf_c) begin
        ctr_err <= 1'b1;
      end
    end
  end

  assign ks_rd_blk    = ks_rd_c;
  assign bus.pt_ready = pt_ready_c;
  assign pt_beat_c    = '{last: bus.pt_last, data: bus.pt_data ^ ks_data};

`ifdef CHACHA_XOR_SKIDBUF_EN
  chacha_beat_t ct_beat;
  logic         skid_in_ready_c;

  chacha_skid_reg u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (fire_c),
    .in_beat    (pt_beat_c),
    .in_ready_c (skid_in_ready_c),
    .out_valid  (bus.ct_valid),
    .out_beat   (ct_beat),
    .out_ready  (bus.ct_ready)
  );

  assign out_ready_c = skid_in_ready_c;
  assign bus.ct_data = ct_beat.data;
  assign bus.ct_last = ct_beat.last;
`else
  logic ct_valid_c;

  // Zero-latency path: ciphertext is presented while the plaintext byte is offered.
  assign ct_valid_c   = (state_q == STREAM) & bus.pt_valid & ks_blk_ready;
  assign out_ready_c  = bus.ct_ready;
  assign bus.ct_valid = ct_valid_c;
  assign bus.ct_data  = ct_valid_c ? pt_beat_c.data : '0;
  assign bus.ct_last  = ct_valid_c & pt_beat_c.last;
`endif

endmodule
